ball_speed_ctrl: RTL and testbench

Rally speed controller that generates the `ball_speed` compare value for the ball clock divider. It starts each rally at a slow initial value and shortens the divider period by a fixed step on every accepted paddle hit, down to a floor. On a point it returns to the initial value. It sits between the collision/scoring logic and the divider, and also reports rally status and the hit count for the score display.

---
 rtl/ball_speed_ctrl.sv | 70 +++++++
 tb/tb_ball_speed_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ball_speed_ctrl.sv
// ball_speed_ctrl: rally speed controller producing the ball divider compare value, hit count and rally status
module ball_speed_ctrl #(
  parameter logic [25:0] SPEED_INIT  = 26'd25_000_000,
  parameter logic [25:0] SPEED_STEP  = 26'd2_000_000,
  parameter logic [25:0] SPEED_MIN   = 26'd5_000_000,
  parameter logic [15:0] LOCK_CYCLES = 16'd1000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        serve,
  input  logic        hit,
  input  logic        point_scored,
  output logic [25:0] ball_speed,
  output logic [7:0]  hit_count,
  output logic        speed_changed,
  output logic        rally_active
);
  typedef enum logic [1:0] {IDLE, RALLY, HOLD} state_t;
  state_t      state_q, state_d;
  logic [25:0] speed_q, speed_d, hit_speed;
  logic [7:0]  count_q, count_d;
  logic [15:0] lock_q, lock_d;
  logic        chg_q, chg_d, hit_prev_q, hit_rise, at_floor;
  always_comb begin
    hit_rise  = hit & ~hit_prev_q;
    at_floor  = {1'b0, speed_q} < {1'b0, SPEED_MIN} + {1'b0, SPEED_STEP};
    hit_speed = at_floor ? SPEED_MIN : speed_q - SPEED_STEP;
    state_d   = state_q;
    speed_d   = speed_q;
    count_d   = count_q;
    lock_d    = lock_q;
    if (state_q == IDLE) begin
      state_d = serve ? RALLY : IDLE;
    end else if (point_scored) begin
      state_d = IDLE;
      speed_d = SPEED_INIT;
      count_d = '0;
    end else if (state_q == RALLY && hit_rise) begin
      state_d = HOLD;
      speed_d = hit_speed;
      count_d = count_q + {7'd0, count_q != 8'hff};
      lock_d  = LOCK_CYCLES - 16'd1;
    end else if (state_q == HOLD) begin
      state_d = lock_q == '0 ? RALLY : HOLD;
      lock_d  = lock_q == '0 ? lock_q : lock_q - 16'd1;
    end
    chg_d = speed_d != speed_q;
  end
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      speed_q    <= SPEED_INIT;
      count_q    <= '0;
      lock_q     <= '0;
      chg_q      <= 1'b0;
      hit_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      speed_q    <= speed_d;
      count_q    <= count_d;
      lock_q     <= lock_d;
      chg_q      <= chg_d;
      hit_prev_q <= hit;
    end
  end
  assign ball_speed    = speed_q;
  assign hit_count     = count_q;
  assign speed_changed = chg_q;
  assign rally_active  = state_q != IDLE;
endmodule

// File: tb/tb_ball_speed_ctrl.sv
// tb_ball_speed_ctrl: vector table, directed corner sequences and random stimulus against a cycle-count reference model
module tb_ball_speed_ctrl;
  localparam longint INIT = 25_000_000;
  localparam longint STEP = 2_000_000;
  localparam longint MINS = 5_000_000;
  localparam int     LOCK = 1000;
  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        serve = 1'b0;
  logic        hit = 1'b0;
  logic        point_scored = 1'b0;
  logic [25:0] ball_speed;
  logic [7:0]  hit_count;
  logic        speed_changed;
  logic        rally_active;
  int total = 0;
  int bad = 0;
  bit m_rally, m_prev, m_chg;
  int m_hits, m_ok, t;
  typedef struct {
    bit          s;
    bit          h;
    bit          p;
    int          n;
    logic [25:0] sp;
    logic [7:0]  cnt;
    bit          chg;
    bit          act;
  } vec_t;
  vec_t vecs [19];
  ball_speed_ctrl dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .serve(serve),
    .hit(hit),
    .point_scored(point_scored),
    .ball_speed(ball_speed),
    .hit_count(hit_count),
    .speed_changed(speed_changed),
    .rally_active(rally_active)
  );
  always #5 clk_in = ~clk_in;
  function automatic longint spd(int n);
    longint v = INIT - longint'(n) * STEP;
    return v < MINS ? MINS : v;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_rally = 0;
    m_prev  = 0;
    m_chg   = 0;
    m_hits  = 0;
    m_ok    = 0;
  endtask
  task automatic model_edge();
    bit rise = hit && !m_prev;
    longint old = spd(m_hits);
    if (!m_rally) begin
      if (serve) begin
        m_rally = 1;
        m_ok = t + 1;
      end
    end else if (point_scored) begin
      m_rally = 0;
      m_hits = 0;
    end else if (rise && t >= m_ok) begin
      m_hits++;
      m_ok = t + LOCK + 1;
    end
    m_prev = hit;
    m_chg = spd(m_hits) != old;
    t++;
  endtask
  task automatic check_model();
    check("model speed", ball_speed, spd(m_hits));
    check("model count", hit_count, m_hits > 255 ? 255 : m_hits);
    check("model changed", speed_changed, m_chg);
    check("model active", rally_active, m_rally);
  endtask
  task automatic tick(input bit s, input bit h, input bit p);
    serve = s;
    hit = h;
    point_scored = p;
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check_model();
  endtask
  task automatic run(input bit s, input bit h, input bit p, input int n);
    repeat (n) tick(s, h, p);
  endtask
  task automatic check_out(input string name, input longint sp, input int cnt, input bit chg, input bit act);
    check({name, " speed"}, ball_speed, sp);
    check({name, " count"}, hit_count, cnt);
    check({name, " changed"}, speed_changed, chg);
    check({name, " active"}, rally_active, act);
  endtask
  initial begin
    bit h;
    vecs = '{
      '{1, 0, 0, 1,    26'd25_000_000, 8'd0, 0, 1},
      '{0, 1, 0, 1,    26'd23_000_000, 8'd1, 1, 1},
      '{0, 0, 0, 1,    26'd23_000_000, 8'd1, 0, 1},
      '{0, 0, 0, 1098, 26'd23_000_000, 8'd1, 0, 1},
      '{0, 1, 0, 1,    26'd21_000_000, 8'd2, 1, 1},
      '{0, 0, 0, 1099, 26'd21_000_000, 8'd2, 0, 1},
      '{0, 1, 0, 1,    26'd19_000_000, 8'd3, 1, 1},
      '{0, 0, 0, 1099, 26'd19_000_000, 8'd3, 0, 1},
      '{0, 1, 1, 1,    26'd25_000_000, 8'd0, 1, 0},
      '{0, 0, 0, 1,    26'd25_000_000, 8'd0, 0, 0},
      '{1, 0, 0, 1,    26'd25_000_000, 8'd0, 0, 1},
      '{0, 1, 0, 1,    26'd23_000_000, 8'd1, 1, 1},
      '{0, 0, 0, 499,  26'd23_000_000, 8'd1, 0, 1},
      '{0, 1, 0, 1,    26'd23_000_000, 8'd1, 0, 1},
      '{0, 1, 0, 5000, 26'd23_000_000, 8'd1, 0, 1},
      '{0, 0, 0, 1,    26'd23_000_000, 8'd1, 0, 1},
      '{0, 1, 0, 1,    26'd21_000_000, 8'd2, 1, 1},
      '{0, 1, 0, 4999, 26'd21_000_000, 8'd2, 0, 1},
      '{0, 0, 1, 1,    26'd25_000_000, 8'd0, 1, 0}
    };
    t = 0;
    model_reset();
    repeat (4) begin
      @(negedge clk_in);
      serve = 1'($urandom);
      hit = 1'($urandom);
      point_scored = 1'($urandom);
    end
    @(negedge clk_in);
    check_out("reset", INIT, 0, 0, 0);
    serve = 0;
    rst_n = 1'b1;
    run(0, 1, 0, 20);
    check_out("no serve", INIT, 0, 0, 0);
    for (int i = 0; i < $size(vecs); i++) begin
      run(vecs[i].s, vecs[i].h, vecs[i].p, vecs[i].n);
      check_out($sformatf("vec%0d", i), longint'(vecs[i].sp), int'(vecs[i].cnt), vecs[i].chg, vecs[i].act);
    end
    tick(1, 0, 0);
    for (int i = 1; i <= 11; i++) begin
      tick(0, 1, 0);
      check_out($sformatf("floor hit%0d", i), i <= 10 ? INIT - STEP * i : MINS, i, i <= 10, 1);
      run(0, 0, 0, 1099);
    end
    tick(0, 0, 1);
    check_out("floor point", INIT, 0, 1, 0);
    tick(1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      tick(0, 1, 0);
      run(0, 0, 0, i < 4 ? 1099 : 200);
    end
    check_out("pre async", INIT - 4 * STEP, 4, 0, 1);
    #2 rst_n = 1'b0;
    #1 check_out("async reset", INIT, 0, 0, 0);
    model_reset();
    @(negedge clk_in);
    rst_n = 1'b1;
    run(0, 1, 0, 5);
    run(0, 0, 0, 5);
    run(0, 1, 0, 5);
    check_out("post reset idle", INIT, 0, 0, 0);
    tick(1, 1, 0);
    check_out("reserve", INIT, 0, 0, 1);
    h = 0;
    repeat (20000) begin
      if ($urandom_range(0, 299) == 0) h = !h;
      tick($urandom_range(0, 49) == 0, h, $urandom_range(0, 2999) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
